// File: rtl/cpu_alu.sv
// cpu_alu: 8-bit ALU with registered result/flags and tri-state drivers onto adl, sb and db.
// Define ALU_DECIMAL_EN to compile in packed-BCD adjust for sums/subs (dec_en).
module cpu_alu (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic       cin,
    input  logic       sums,
    input  logic       subs,
    input  logic       ands,
    input  logic       eors,
    input  logic       ors,
    input  logic       shftr,
    input  logic       shftcr,
    input  logic       dec_en,
    input  logic       aluadloa,
    input  logic       alusboa,
    input  logic       aludbwa,
    inout  wire  [7:0] adl,
    inout  wire  [7:0] sb,
    inout  wire  [7:0] db,
    output logic       cout,
    output logic       zero,
    output logic       overflow,
    output logic       neg
);

    logic [7:0] res_q, res_d;
    logic       c_q, c_d, v_q, v_d, z_q, n_q;
    logic       any_op;
    logic [7:0] b_eff;
    logic [8:0] bin;
    logic       bin_v;

    assign any_op = sums | subs | ands | eors | ors | shftr | shftcr;

    // Subtraction is a + ~b + cin, so cin=1 and cout=1 both mean "no borrow".
    assign b_eff = sums ? b_in : ~b_in;
    assign bin   = {1'b0, a_in} + {1'b0, b_eff} + {8'b0, cin};
    assign bin_v = (a_in[7] == b_eff[7]) && (bin[7] != a_in[7]);

`ifdef ALU_DECIMAL_EN
    logic [4:0] lo_add;
    logic       lo_borrow;
    logic [9:0] dadd;
    logic       dec_c;
    logic [7:0] dec_add_res;
    logic [7:0] dec_sub_res;

    always_comb begin
        lo_add      = {1'b0, a_in[3:0]} + {1'b0, b_in[3:0]} + {4'b0, cin};
        lo_borrow   = {1'b0, a_in[3:0]} < ({1'b0, b_in[3:0]} + {4'b0, ~cin});
        dadd        = {1'b0, bin} + ((lo_add > 5'd9) ? 10'h006 : 10'h000);
        dec_c       = dadd > 10'h099;
        dec_add_res = dadd[7:0] + (dec_c ? 8'h60 : 8'h00);
        dec_sub_res = bin[7:0] - (lo_borrow ? 8'h06 : 8'h00) - (bin[8] ? 8'h00 : 8'h60);
    end
`else
    logic unused_dec_en;
    assign unused_dec_en = dec_en;
`endif

    always_comb begin
        res_d = res_q;
        c_d   = c_q;
        v_d   = v_q;
        if (sums || subs) begin
            res_d = bin[7:0];
            c_d   = bin[8];
            v_d   = bin_v;
`ifdef ALU_DECIMAL_EN
            if (dec_en) begin
                res_d = sums ? dec_add_res : dec_sub_res;
                c_d   = sums ? dec_c : bin[8];
            end
`endif
        end else if (ands) begin
            res_d = a_in & b_in;
            c_d   = 1'b0;
            v_d   = 1'b0;
        end else if (eors) begin
            res_d = a_in ^ b_in;
            c_d   = 1'b0;
            v_d   = 1'b0;
        end else if (ors) begin
            res_d = a_in | b_in;
            c_d   = 1'b0;
            v_d   = 1'b0;
        end else if (shftr || shftcr) begin
            res_d = {shftcr & cin, a_in[7:1]};
            c_d   = a_in[0];
            v_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            res_q <= 8'h00;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
        end else if (any_op) begin
            res_q <= res_d;
            c_q   <= c_d;
            v_q   <= v_d;
            z_q   <= (res_d == 8'h00);
            n_q   <= res_d[7];
        end
    end

    assign cout     = c_q;
    assign overflow = v_q;
    assign zero     = z_q;
    assign neg      = n_q;

    assign adl = aluadloa ? res_q : 8'bz;
    assign sb  = alusboa  ? res_q : 8'bz;
    assign db  = aludbwa  ? res_q : 8'bz;

endmodule

// File: tb/tb_cpu_alu.sv
// Self-checking bench for cpu_alu: integer reference model plus directed literal vectors.
// Honours ALU_DECIMAL_EN the same way the design does.
module tb_cpu_alu;

`ifdef ALU_DECIMAL_EN
    localparam bit DecOn = 1'b1;
`else
    localparam bit DecOn = 1'b0;
`endif

    localparam logic [6:0] OpS   = 7'b1000000;
    localparam logic [6:0] OpSub = 7'b0100000;
    localparam logic [6:0] OpAnd = 7'b0010000;
    localparam logic [6:0] OpEor = 7'b0001000;
    localparam logic [6:0] OpOr  = 7'b0000100;
    localparam logic [6:0] OpSr  = 7'b0000010;
    localparam logic [6:0] OpScr = 7'b0000001;

    logic       clk, clr;
    logic [7:0] a_in, b_in;
    logic       cin, dec_en, aluadloa, alusboa, aludbwa;
    logic [6:0] sel;
    logic       sums, subs, ands, eors, ors, shftr, shftcr;
    wire  [7:0] adl, sb, db;
    logic       cout, zero, overflow, neg;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    logic [7:0] m_res = 8'h00;
    logic       m_c = 1'b0, m_v = 1'b0, m_z = 1'b0, m_n = 1'b0;
    logic [9:0] nx;

    assign {sums, subs, ands, eors, ors, shftr, shftcr} = sel;

    // A released bus picks up the bench's own pattern (~model result) instead of floating.
    assign adl = aluadloa ? 8'bz : ~m_res;
    assign sb  = alusboa  ? 8'bz : ~m_res;
    assign db  = aludbwa  ? 8'bz : ~m_res;

    cpu_alu dut (
        .clk      (clk),
        .clr      (clr),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .sums     (sums),
        .subs     (subs),
        .ands     (ands),
        .eors     (eors),
        .ors      (ors),
        .shftr    (shftr),
        .shftcr   (shftcr),
        .dec_en   (dec_en),
        .aluadloa (aluadloa),
        .alusboa  (alusboa),
        .aludbwa  (aludbwa),
        .adl      (adl),
        .sb       (sb),
        .db       (db),
        .cout     (cout),
        .zero     (zero),
        .overflow (overflow),
        .neg      (neg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns {result, carry, overflow} using plain integer arithmetic.
    function automatic logic [9:0] model_fn(input logic [6:0] s, input logic [7:0] a,
                                            input logic [7:0] b, input logic ci,
                                            input logic dec);
        int ia, ib, ic, sa, sbv, t, lo, sv;
        logic c, v;
        ia = int'(a);
        ib = int'(b);
        ic = ci ? 1 : 0;
        sa = a[7] ? ia - 256 : ia;
        sbv = b[7] ? ib - 256 : ib;
        t = 0;
        c = 1'b0;
        v = 1'b0;
        if (s[6]) begin
            t = ia + ib + ic;
            sv = sa + sbv + ic;
            v = (sv > 127) || (sv < -128);
            c = t > 255;
            if (DecOn && dec) begin
                lo = ia % 16 + ib % 16 + ic;
                if (lo > 9) t = t + 6;
                c = t > 153;
                if (c) t = t + 96;
            end
        end else if (s[5]) begin
            t = ia - ib - (1 - ic);
            sv = sa - sbv - (1 - ic);
            v = (sv > 127) || (sv < -128);
            c = t >= 0;
            if (DecOn && dec) begin
                lo = ia % 16 - ib % 16 - (1 - ic);
                if (lo < 0) t = t - 6;
                if (!c) t = t - 96;
            end
        end else if (s[4]) begin
            t = ia & ib;
        end else if (s[3]) begin
            t = ia ^ ib;
        end else if (s[2]) begin
            t = ia | ib;
        end else if (s[1]) begin
            t = ia / 2;
            c = a[0];
        end else if (s[0]) begin
            t = ia / 2 + 128 * ic;
            c = a[0];
        end
        return {8'(t), c, v};
    endfunction

    assign nx = model_fn(sel, a_in, b_in, cin, dec_en);

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_res <= 8'h00;
            m_c   <= 1'b0;
            m_v   <= 1'b0;
            m_z   <= 1'b0;
            m_n   <= 1'b0;
        end else if (sel != 7'b0) begin
            m_res <= nx[9:2];
            m_c   <= nx[1];
            m_v   <= nx[0];
            m_z   <= (nx[9:2] == 8'h00);
            m_n   <= nx[9];
        end
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cmp_adl", adl, m_res ^ {8{~aluadloa}});
            check("cmp_sb", sb, m_res ^ {8{~alusboa}});
            check("cmp_db", db, m_res ^ {8{~aludbwa}});
            check("cmp_flags", {4'b0, cout, overflow, zero, neg}, {4'b0, m_c, m_v, m_z, m_n});
        end
    end

    // Called at posedge+2; applies one op for one edge and checks sb and {C,V,Z,N}.
    task automatic do_op(input string nm, input logic [6:0] s, input logic [7:0] a,
                         input logic [7:0] b, input logic ci, input logic dec,
                         input logic [7:0] er, input logic [3:0] ecvzn);
        sel    = s;
        a_in   = a;
        b_in   = b;
        cin    = ci;
        dec_en = dec;
        @(posedge clk);
        #2;
        sel = 7'b0;
        check({nm, "_res"}, sb, er);
        check({nm, "_cvzn"}, {4'b0, cout, overflow, zero, neg}, {4'b0, ecvzn});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0;
        sel = 7'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        cin = 1'b0;
        dec_en = 1'b0;
        aluadloa = 1'b0;
        alusboa = 1'b1;
        aludbwa = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_sb", sb, 8'h00);
        check("reset_cvzn", {4'b0, cout, overflow, zero, neg}, 8'h00);
        clr = 1'b1;
        chk_on = 1'b1;
        @(posedge clk);
        #2;

        do_op("add55", OpS, 8'h55, 8'h55, 1'b0, 1'b0, 8'hAA, 4'b0101);
        do_op("sub10_20", OpSub, 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 4'b0001);
        do_op("sub20_10", OpSub, 8'h20, 8'h10, 1'b1, 1'b0, 8'h10, 4'b1000);
        do_op("shftcr", OpScr, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1001);
        do_op("shftr", OpSr, 8'h81, 8'h00, 1'b1, 1'b0, 8'h40, 4'b1000);
        do_op("wrap", OpS, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b1010);
        do_op("and", OpAnd, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h24, 4'b0000);
        do_op("eor", OpEor, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h99, 4'b0001);
        do_op("or", OpOr, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'hBD, 4'b0001);
        do_op("and_eor", OpAnd | OpEor, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 4'b0000);
        do_op("sub_or", OpSub | OpOr, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 4'b1100);
        do_op("add_ovf", OpS, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 4'b0101);
        if (DecOn) begin
            do_op("bcd19_28", OpS, 8'h19, 8'h28, 1'b0, 1'b1, 8'h47, 4'b0000);
            do_op("bcd99_01", OpS, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 4'b1010);
            do_op("bcdsub", OpSub, 8'h10, 8'h01, 1'b1, 1'b1, 8'h09, 4'b1000);
        end else begin
            do_op("bin19_28", OpS, 8'h19, 8'h28, 1'b0, 1'b1, 8'h41, 4'b0000);
            do_op("bin99_01", OpS, 8'h99, 8'h01, 1'b0, 1'b1, 8'h9A, 4'b0001);
            do_op("binsub", OpSub, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 4'b1000);
        end
        dec_en = 1'b0;
        do_op("add_and", OpS | OpAnd, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 4'b0001);

        repeat (3) @(posedge clk);
        #2;
        check("hold_res", sb, 8'hFF);
        check("hold_cvzn", {4'b0, cout, overflow, zero, neg}, 8'h01);

        // Reset lands mid-cycle while an add is pending, and is held across an edge.
        sel = OpS;
        a_in = 8'h01;
        b_in = 8'h01;
        cin = 1'b0;
        aluadloa = 1'b1;
        aludbwa = 1'b1;
        #1;
        clr = 1'b0;
        #1;
        check("clr_sb", sb, 8'h00);
        check("clr_adl", adl, 8'h00);
        check("clr_cvzn", {4'b0, cout, overflow, zero, neg}, 8'h00);
        @(posedge clk);
        #2;
        check("clr_held", sb, 8'h00);
        clr = 1'b1;
        @(posedge clk);
        #2;
        sel = 7'b0;
        check("post_clr_sb", sb, 8'h02);
        check("post_clr_adl", adl, 8'h02);
        check("post_clr_db", db, 8'h02);
        check("post_clr_cvzn", {4'b0, cout, overflow, zero, neg}, 8'h00);

        aluadloa = 1'b0;
        alusboa = 1'b0;
        aludbwa = 1'b0;
        #1;
        check("off_adl", adl, 8'hFD);
        check("off_sb", sb, 8'hFD);
        check("off_db", db, 8'hFD);
        repeat (2) @(posedge clk);
        #2;
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
